// File: rtl/hstream_align_pkg.sv
// Shared definitions for the hstream_align stream re-aligner.
package hstream_align_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

  // Depth must be a power of two and at least 2 so pointers wrap naturally.
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 32'd0);
  endfunction

  // One stream beat as seen at an input port.
  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/hstream_align_fifo.sv
// Single-clock FIFO with registered ready, head-of-queue output and occupancy count.
module hstream_align_fifo
  import hstream_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          ready,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  wr_en;
  logic                  rd_en;

  // ready mirrors !full of the registered count, so writes never hit a full FIFO.
  assign wr_en = push && ready;
  assign rd_en = pop && !empty;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointer, count and ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hstream_align.sv
// Re-aligns two skewed streams into index-matched pairs on one registered valid/ready port.
// Optional skew monitor: define HSTREAM_ALIGN_SKEW_MON_EN to track peak occupancy difference.
module hstream_align
  import hstream_align_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter logic        HINITIAL   = 1'b0
) (
  input  logic                          hclk,
  input  logic                          hres,
  input  logic                          a_valid,
  input  logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_a,
  output logic [DATA_WIDTH-1:0]         out_b,
  input  logic                          out_ready,
  input  logic                          err_clr,
  output logic                          ovf_a,
  output logic                          ovf_b,
  output logic [cnt_width(DEPTH)-1:0]   skew_max
);

  localparam int unsigned CW = cnt_width(DEPTH);

  // Reject illegal depths at elaboration.
  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("hstream_align: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  empty_a;
  logic                  empty_b;
  logic [CW-1:0]         count_a;
  logic [CW-1:0]         count_b;
  logic                  pop;

  hstream_align_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_a (
    .clk   (hclk),
    .rst   (hres),
    .push  (a_valid),
    .din   (a_data),
    .pop   (pop),
    .head  (head_a),
    .ready (a_ready),
    .empty (empty_a),
    .count (count_a)
  );

  hstream_align_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_b (
    .clk   (hclk),
    .rst   (hres),
    .push  (b_valid),
    .din   (b_data),
    .pop   (pop),
    .head  (head_b),
    .ready (b_ready),
    .empty (empty_b),
    .count (count_b)
  );

  // A pair leaves only when both heads exist and the output register is free.
  assign pop = !empty_a && !empty_b && (!out_valid || out_ready);

  // Output register with hold-under-backpressure behaviour.
  always_ff @(posedge hclk or posedge hres) begin
    if (hres) begin
      out_valid <= 1'b0;
      out_a     <= {DATA_WIDTH{HINITIAL}};
      out_b     <= {DATA_WIDTH{HINITIAL}};
    end else if (pop) begin
      out_valid <= 1'b1;
      out_a     <= head_a;
      out_b     <= head_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow flags; a new overflow wins over a clear in the same cycle.
  always_ff @(posedge hclk or posedge hres) begin
    if (hres) begin
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      if (a_valid && !a_ready) ovf_a <= 1'b1;
      else if (err_clr)        ovf_a <= 1'b0;
      if (b_valid && !b_ready) ovf_b <= 1'b1;
      else if (err_clr)        ovf_b <= 1'b0;
    end
  end

`ifdef HSTREAM_ALIGN_SKEW_MON_EN
  logic [CW-1:0] skew_now;

  // Instantaneous occupancy difference from the registered counts.
  always_comb begin
    skew_now = (count_a >= count_b) ? (count_a - count_b) : (count_b - count_a);
  end

  // Peak-hold of the skew, cleared alongside the error flags.
  always_ff @(posedge hclk or posedge hres) begin
    if (hres) begin
      skew_max <= '0;
    end else if (err_clr) begin
      skew_max <= '0;
    end else if (skew_now > skew_max) begin
      skew_max <= skew_now;
    end
  end
`else
  logic unused_counts;

  assign unused_counts = ^{count_a, count_b};
  assign skew_max      = '0;
`endif

endmodule

// File: tb/tb_hstream_align.sv
// Scoreboard bench for hstream_align: stimulus queues expected words, a monitor checks pairs.
module tb_hstream_align;
  import hstream_align_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned CW = cnt_width(DP);

  logic          hclk = 1'b0;
  logic          hres = 1'b0;
  logic          a_valid = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          out_valid;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_ready = 1'b1;
  logic          err_clr = 1'b0;
  logic          ovf_a;
  logic          ovf_b;
  logic [CW-1:0] skew_max;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  hstream_align #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .HINITIAL   (1'b1)
  ) dut (
    .hclk      (hclk),
    .hres      (hres),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b),
    .skew_max  (skew_max)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic beat_t mk(input logic v, input logic [DW-1:0] d);
    beat_t r;
    r.valid = v;
    r.data  = d;
    return r;
  endfunction

  // Present one beat on each input for a cycle and record what is expected to pair up.
  task automatic drive(input beat_t a, input beat_t b);
    a_valid = a.valid;
    a_data  = a.data;
    b_valid = b.valid;
    b_data  = b.data;
    if (a.valid) exp_a.push_back(a.data);
    if (b.valid) exp_b.push_back(b.data);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected pair has been seen, then confirm the port goes idle.
  task automatic drain(input string name);
    for (int k = 0; k < 300 && (exp_a.size() != 0 || exp_b.size() != 0); k++) tick();
    check({name, "_left_a"}, 32'(exp_a.size()), 32'd0);
    check({name, "_left_b"}, 32'(exp_b.size()), 32'd0);
    tick();
    tick();
    check({name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  // Monitor: every accepted output pair is compared against the next expected words.
  always @(negedge hclk) begin
    if (!hres && out_valid && out_ready) begin
      if (exp_a.size() == 0 || exp_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pair_unexpected: got a=%0h b=%0h, none expected at %0t", out_a, out_b, $time);
      end else begin
        check("pair_a", 32'(out_a), 32'(exp_a.pop_front()));
        check("pair_b", 32'(out_b), 32'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1 hres = 1'b1;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a", 32'(out_a), 32'h0ff);
    check("rst_out_b", 32'(out_b), 32'h0ff);
    check("rst_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    check("rst_skew", 32'(skew_max), 32'd0);
    #2 hres = 1'b0;
    tick();
    check("rst_ready", 32'({a_ready, b_ready}), 32'd3);

    // Zero skew with minimum latency of two cycles
    out_ready = 1'b1;
    drive(mk(1'b1, 8'h11), mk(1'b1, 8'h11));
    check("lat_not_yet", 32'(out_valid), 32'd0);
    drive(mk(1'b1, 8'h22), mk(1'b1, 8'h22));
    check("lat_valid", 32'(out_valid), 32'd1);
    drive(mk(1'b1, 8'h33), mk(1'b1, 8'h33));
    drain("zero_skew");

    // Backpressure: presented pair holds for four cycles
    out_ready = 1'b0;
    drive(mk(1'b1, 8'h5a), mk(1'b1, 8'ha5));
    drive(mk(1'b1, 8'h5b), mk(1'b1, 8'hb5));
    drive(mk(1'b0, 8'h00), mk(1'b0, 8'h00));
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_a", 32'(out_a), 32'h5a);
      check("hold_b", 32'(out_b), 32'ha5);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_a", 32'(out_a), 32'h5b);
    check("bp_next_b", 32'(out_b), 32'hb5);
    drain("backpressure");

    // B lags A by five cycles
    for (int t = 0; t < 13; t++) begin
      drive(mk(t < 8, 8'(8'h40 + t)), mk(t >= 5, 8'(8'hc0 + t - 5)));
    end
    drain("skew5");
`ifdef HSTREAM_ALIGN_SKEW_MON_EN
    check("skew5_max", 32'(skew_max), 32'd5);
`else
    check("skew5_max", 32'(skew_max), 32'd0);
`endif

    // Fill A, overflow, clear, and set-beats-clear
    for (int i = 0; i < 16; i++) drive(mk(1'b1, 8'(8'h80 + i)), mk(1'b0, 8'h00));
    check("full_ready_a", 32'(a_ready), 32'd0);
    check("full_ready_b", 32'(b_ready), 32'd1);
    check("full_no_ovf", 32'(ovf_a), 32'd0);
    a_valid = 1'b1;
    a_data  = 8'hee;
    tick();
    a_valid = 1'b0;
    check("ovf_a_set", 32'(ovf_a), 32'd1);
    check("ovf_b_clear", 32'(ovf_b), 32'd0);
`ifdef HSTREAM_ALIGN_SKEW_MON_EN
    check("full_skew", 32'(skew_max), 32'd16);
`else
    check("full_skew", 32'(skew_max), 32'd0);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_a_cleared", 32'(ovf_a), 32'd0);
    a_valid = 1'b1;
    a_data  = 8'hef;
    err_clr = 1'b1;
    tick();
    a_valid = 1'b0;
    err_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_a), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_a_cleared2", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 16; i++) drive(mk(1'b0, 8'h00), mk(1'b1, 8'(8'h90 + i)));
    drain("overflow");

    // Asynchronous reset mid-stream discards buffered words
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(mk(1'b1, 8'(8'h61 + i)), mk(1'b1, 8'(8'h71 + i)));
    tick();
    #2 hres = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_a", 32'(out_a), 32'h0ff);
    check("mid_rst_b", 32'(out_b), 32'h0ff);
    exp_a.delete();
    exp_b.delete();
    #3 hres = 1'b0;
    tick();
    check("post_rst_ready", 32'({a_ready, b_ready}), 32'd3);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(mk(1'b1, 8'(8'h01 + i)), mk(1'b1, 8'(8'hd1 + i)));
    drain("after_reset");

    // Wrap-around: three FIFO depths with skew 3
    for (int t = 0; t < 51; t++) begin
      drive(mk(t < 48, 8'(t)), mk(t >= 3, 8'(t + 97)));
    end
    drain("wrap");
    check("wrap_count_a", 32'(dut.u_fifo_a.count), 32'd0);
    check("wrap_count_b", 32'(dut.u_fifo_b.count), 32'd0);
`ifdef HSTREAM_ALIGN_SKEW_MON_EN
    check("wrap_skew", 32'(skew_max), 32'd3);
`else
    check("wrap_skew", 32'(skew_max), 32'd0);
`endif
    check("wrap_no_ovf", 32'({ovf_a, ovf_b}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
